// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm keypad controller: FSM states, special key codes and
// the default parameter values.
package alarm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StProgAuth,
    StProgNew,
    StLockout
  } state_e;

  localparam logic [3:0] KEY_NONE  = 4'h0;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_PROG  = 4'hF;

  localparam int unsigned DEF_CODE_LEN      = 4;
  localparam logic [31:0] DEF_CODE          = 32'h0000_1234;
  localparam int unsigned DEF_TIMEOUT_TICKS = 10;
  localparam int unsigned DEF_MAX_FAILS     = 3;
  localparam int unsigned DEF_LOCKOUT_TICKS = 40;

  // One nibble of ones per code digit, lowest nibble is the last-entered digit.
  function automatic logic [31:0] code_mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < len) m[i*4 +: 4] = 4'hF;
    end
    return m;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_keypad_ctrl_if.sv
// Keypad-side signal bundle of the alarm keypad controller. The master drives the keypad, tick
// and armed status; the slave (the controller) returns requests and status.
interface alarm_keypad_ctrl_if;
  logic       ENA;
  logic [3:0] keypad;
  logic       is_armed;
  logic       arm_req;
  logic       disarm_req;
  logic       code_err;
  logic       code_changed;
  logic       locked;
  logic [3:0] digit_cnt;

  modport master (
    output ENA, keypad, is_armed,
    input  arm_req, disarm_req, code_err, code_changed, locked, digit_cnt
  );

  modport slave (
    input  ENA, keypad, is_armed,
    output arm_req, disarm_req, code_err, code_changed, locked, digit_cnt
  );
endinterface

// File: rtl/keypad_event_det.sv
// Samples the keypad on ENA ticks and flags a key event when a non-zero code follows a zero
// sample, so a held key produces exactly one event.
module keypad_event_det
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic [3:0] keypad,
  output logic       key_evt,
  output logic [3:0] key_val
);

  logic [3:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= KEY_NONE;
    end else if (ENA) begin
      prev_q <= keypad;
    end
  end

  always_comb begin
    key_evt = ENA && (keypad != KEY_NONE) && (prev_q == KEY_NONE);
    key_val = keypad;
  end

endmodule

// File: rtl/alarm_keypad_ctrl.sv
// Keypad code-entry controller: collects digits, checks or reprograms the code and issues
// arm/disarm requests. Define KEYPAD_LOCKOUT_EN to lock the keypad after repeated wrong codes.
module alarm_keypad_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned CODE_LEN      = DEF_CODE_LEN,
  parameter logic [31:0] DEFAULT_CODE  = DEF_CODE,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int unsigned MAX_FAILS     = DEF_MAX_FAILS,
  parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
  input logic                 clk,
  input logic                 reset,
  alarm_keypad_ctrl_if.slave  bus
);

  localparam logic [31:0] Mask  = code_mask(CODE_LEN);
  // One tick counter serves both the inactivity timeout and the lockout period.
  localparam int unsigned TickW = $clog2(max_u(TIMEOUT_TICKS, LOCKOUT_TICKS) + 1);
  localparam int unsigned FailW = max_u($clog2(MAX_FAILS + 1), 4);

  state_e             state_q, state_d;
  logic [31:0]        entry_q, entry_d;
  logic [31:0]        code_q, code_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [FailW-1:0]   fail_q, fail_d;
  logic               arm_q, arm_d;
  logic               disarm_q, disarm_d;
  logic               err_q, err_d;
  logic               chg_q, chg_d;
  logic               locked_q, locked_d;

  logic               key_evt;
  logic [3:0]         key_val;
  logic               is_digit;
  logic [31:0]        entry_shift;
  logic               shift_match;
  logic               entry_match;
  logic               last_digit;
  logic [TickW-1:0]   tick_inc;
  logic               tmo_hit;
  logic [FailW-1:0]   fail_inc;
  state_e             fail_state;

  keypad_event_det u_event_det (
    .clk     (clk),
    .reset   (reset),
    .ENA     (bus.ENA),
    .keypad  (bus.keypad),
    .key_evt (key_evt),
    .key_val (key_val)
  );

  always_comb begin
    is_digit    = (key_val != KEY_CLEAR) && (key_val != KEY_PROG);
    entry_shift = {entry_q[27:0], key_val} & Mask;
    shift_match = (entry_shift == code_q);
    entry_match = (entry_q == code_q);
    last_digit  = ((cnt_q + 4'd1) == 4'(CODE_LEN));
    tick_inc    = tick_q + TickW'(1);
    tmo_hit     = (tick_inc == TickW'(TIMEOUT_TICKS));
    fail_inc    = (&fail_q) ? fail_q : fail_q + FailW'(1);
`ifdef KEYPAD_LOCKOUT_EN
    fail_state  = (fail_inc >= FailW'(MAX_FAILS)) ? StLockout : StIdle;
`else
    fail_state  = StIdle;
`endif
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    tick_d   = tick_q;
    fail_d   = fail_q;
    arm_d    = 1'b0;
    disarm_d = 1'b0;
    err_d    = 1'b0;
    chg_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_evt) begin
          if (is_digit) begin
            state_d = StEntry;
            entry_d = {28'd0, key_val};
            cnt_d   = 4'd1;
            tick_d  = '0;
          end else if (key_val == KEY_PROG && !bus.is_armed) begin
            state_d = StProgAuth;
            entry_d = '0;
            cnt_d   = '0;
            tick_d  = '0;
          end
        end
      end

      StEntry, StProgAuth, StProgNew: begin
        if (key_evt) begin
          tick_d = '0;
          if (key_val == KEY_CLEAR) begin
            state_d = StIdle;
            entry_d = '0;
            cnt_d   = '0;
          end else if (is_digit) begin
            entry_d = entry_shift;
            cnt_d   = cnt_q + 4'd1;
            if (last_digit) begin
              cnt_d = '0;
              if (state_q == StEntry) begin
                state_d = StCheck;
              end else if (state_q == StProgAuth) begin
                entry_d = '0;
                if (shift_match) begin
                  state_d = StProgNew;
                  fail_d  = '0;
                end else begin
                  state_d = fail_state;
                  err_d   = 1'b1;
                  fail_d  = fail_inc;
                end
              end else begin
                code_d  = entry_shift;
                chg_d   = 1'b1;
                state_d = StIdle;
                entry_d = '0;
              end
            end
          end
        end else if (bus.ENA) begin
          if (tmo_hit) begin
            state_d = StIdle;
            err_d   = 1'b1;
            entry_d = '0;
            cnt_d   = '0;
            tick_d  = '0;
          end else begin
            tick_d = tick_inc;
          end
        end
      end

      StCheck: begin
        state_d = StIdle;
        entry_d = '0;
        tick_d  = '0;
        if (entry_match) begin
          fail_d = '0;
          if (bus.is_armed) disarm_d = 1'b1;
          else              arm_d    = 1'b1;
        end else begin
          err_d   = 1'b1;
          fail_d  = fail_inc;
          state_d = fail_state;
        end
      end

`ifdef KEYPAD_LOCKOUT_EN
      StLockout: begin
        if (bus.ENA) begin
          if (tick_inc == TickW'(LOCKOUT_TICKS)) begin
            state_d = StIdle;
            fail_d  = '0;
            tick_d  = '0;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase

`ifdef KEYPAD_LOCKOUT_EN
    locked_d = (state_d == StLockout);
`else
    locked_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      entry_q  <= '0;
      code_q   <= DEFAULT_CODE & Mask;
      cnt_q    <= '0;
      tick_q   <= '0;
      fail_q   <= '0;
      arm_q    <= 1'b0;
      disarm_q <= 1'b0;
      err_q    <= 1'b0;
      chg_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      fail_q   <= fail_d;
      arm_q    <= arm_d;
      disarm_q <= disarm_d;
      err_q    <= err_d;
      chg_q    <= chg_d;
      locked_q <= locked_d;
    end
  end

  assign bus.arm_req      = arm_q;
  assign bus.disarm_req   = disarm_q;
  assign bus.code_err     = err_q;
  assign bus.code_changed = chg_q;
  assign bus.locked       = locked_q;
  assign bus.digit_cnt    = cnt_q;

endmodule

// File: tb/tb_alarm_keypad_ctrl.sv
// Self-checking bench for alarm_keypad_ctrl: directed scenarios plus random key traffic, all
// checked per ENA tick against a digit-queue reference model.
module tb_alarm_keypad_ctrl;
  import alarm_pkg::*;

  localparam int          CODE_LEN      = int'(DEF_CODE_LEN);
  localparam logic [31:0] DEFAULT_CODE  = DEF_CODE;
  localparam int          TIMEOUT_TICKS = int'(DEF_TIMEOUT_TICKS);
  localparam int          MAX_FAILS     = int'(DEF_MAX_FAILS);
  localparam int          LOCKOUT_TICKS = int'(DEF_LOCKOUT_TICKS);
`ifdef KEYPAD_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int MIdle = 0, MEntry = 1, MAuth = 2, MNew = 3, MLock = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_keypad_ctrl_if kif ();

  alarm_keypad_ctrl #(
    .CODE_LEN      (DEF_CODE_LEN),
    .DEFAULT_CODE  (DEFAULT_CODE),
    .TIMEOUT_TICKS (DEF_TIMEOUT_TICKS),
    .MAX_FAILS     (DEF_MAX_FAILS),
    .LOCKOUT_TICKS (DEF_LOCKOUT_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  int    checks = 0;
  int    errors = 0;
  string tname  = "none";
  int    tick_no = 0;

  // Reference model: entered digits and stored code as digit queues.
  int m_code[$];
  int m_entry[$];
  int m_mode, m_prev, m_fails, m_idle, m_lock_left;
  bit m_armed;

  task automatic model_reset();
    m_code.delete();
    for (int i = CODE_LEN - 1; i >= 0; i--) m_code.push_back(int'((DEFAULT_CODE >> (4 * i)) & 32'hF));
    m_entry.delete();
    m_mode = MIdle; m_prev = 0; m_fails = 0; m_idle = 0; m_lock_left = 0; m_armed = 1'b0;
  endtask

  task automatic model_fail();
    m_fails++;
    if (LOCK_EN && m_fails >= MAX_FAILS) begin
      m_mode = MLock;
      m_lock_left = LOCKOUT_TICKS;
    end else begin
      m_mode = MIdle;
    end
  endtask

  task automatic model_step(input int k, output int e_arm, output int e_dis, output int e_err,
                            output int e_chg);
    bit ev, match;
    ev = (k != 0) && (m_prev == 0);
    m_prev = k;
    e_arm = 0; e_dis = 0; e_err = 0; e_chg = 0;
    if (m_mode == MLock) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_mode = MIdle; m_fails = 0; end
    end else if (m_mode == MIdle) begin
      if (ev && k >= 1 && k <= 13) begin
        m_entry = {k}; m_mode = MEntry; m_idle = 0;
      end else if (ev && k == 15 && !m_armed) begin
        m_entry = {}; m_mode = MAuth; m_idle = 0;
      end
    end else if (ev) begin
      m_idle = 0;
      if (k == 14) begin
        m_entry = {}; m_mode = MIdle;
      end else if (k != 15) begin
        m_entry.push_back(k);
        if (m_entry.size() == CODE_LEN) begin
          match = 1'b1;
          for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) match = 1'b0;
          if (m_mode == MNew) begin
            m_code = m_entry; e_chg = 1; m_mode = MIdle;
          end else if (match) begin
            m_fails = 0;
            if (m_mode == MAuth) m_mode = MNew;
            else begin
              if (m_armed) e_dis = 1; else e_arm = 1;
              m_mode = MIdle;
            end
          end else begin
            e_err = 1;
            model_fail();
          end
          m_entry = {};
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT_TICKS) begin
        e_err = 1; m_entry = {}; m_mode = MIdle;
      end
    end
  endtask

  // One ENA tick with keypad=k, followed by three quiet clocks; every output sampled each clock.
  task automatic press(input logic [3:0] k);
    int e_arm, e_dis, e_err, e_chg, e_cnt;
    int o_arm, o_dis, o_err, o_chg, o_multi;
    bit e_lock;
    o_arm = 0; o_dis = 0; o_err = 0; o_chg = 0; o_multi = 0;
    @(negedge clk);
    kif.keypad = k;
    kif.ENA = 1'b1;
    model_step(int'(k), e_arm, e_dis, e_err, e_chg);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) kif.ENA = 1'b0;
      o_arm += int'(kif.arm_req);
      o_dis += int'(kif.disarm_req);
      o_err += int'(kif.code_err);
      o_chg += int'(kif.code_changed);
      if (int'(kif.arm_req) + int'(kif.disarm_req) + int'(kif.code_err) +
          int'(kif.code_changed) > 1) o_multi++;
    end
    e_cnt  = m_entry.size();
    e_lock = (m_mode == MLock);
    checks++;
    if (o_arm != e_arm) begin
      errors++;
      $display("FAIL %s tick %0d arm_req cycles got %0d want %0d", tname, tick_no, o_arm, e_arm);
    end
    checks++;
    if (o_dis != e_dis) begin
      errors++;
      $display("FAIL %s tick %0d disarm_req cycles got %0d want %0d", tname, tick_no, o_dis, e_dis);
    end
    checks++;
    if (o_err != e_err) begin
      errors++;
      $display("FAIL %s tick %0d code_err cycles got %0d want %0d", tname, tick_no, o_err, e_err);
    end
    checks++;
    if (o_chg != e_chg) begin
      errors++;
      $display("FAIL %s tick %0d code_changed cycles got %0d want %0d", tname, tick_no, o_chg,
               e_chg);
    end
    checks++;
    if (o_multi != 0) begin
      errors++;
      $display("FAIL %s tick %0d overlapping pulses got %0d want 0", tname, tick_no, o_multi);
    end
    checks++;
    if (kif.digit_cnt !== 4'(e_cnt)) begin
      errors++;
      $display("FAIL %s tick %0d digit_cnt got %0d want %0d", tname, tick_no, kif.digit_cnt, e_cnt);
    end
    checks++;
    if (kif.locked !== e_lock) begin
      errors++;
      $display("FAIL %s tick %0d locked got %0b want %0b", tname, tick_no, kif.locked, e_lock);
    end
    if (e_arm != 0) m_armed = 1'b1;
    if (e_dis != 0) m_armed = 1'b0;
    kif.is_armed = m_armed;
    tick_no++;
  endtask

  task automatic key(input logic [3:0] k);
    press(k);
    press(4'h0);
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    key(4'(d0)); key(4'(d1)); key(4'(d2)); key(4'(d3));
  endtask

  task automatic check_outputs_zero(input string what);
    checks++;
    if ({kif.arm_req, kif.disarm_req, kif.code_err, kif.code_changed, kif.locked} !== 5'b0) begin
      errors++;
      $display("FAIL %s %s pulses/locked got %b want 00000", tname, what,
               {kif.arm_req, kif.disarm_req, kif.code_err, kif.code_changed, kif.locked});
    end
    checks++;
    if (kif.digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL %s %s digit_cnt got %0d want 0", tname, what, kif.digit_cnt);
    end
  endtask

  task automatic test_reset();
    tname = "reset";
    reset = 1'b1;
    kif.ENA = 1'b0; kif.keypad = 4'h0; kif.is_armed = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("during reset");
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("after reset");
  endtask

  task automatic test_arm();
    tname = "arm";
    enter_code(1, 2, 3, 4);
  endtask

  task automatic test_disarm();
    tname = "disarm";
    enter_code(1, 2, 3, 5);
    enter_code(1, 2, 3, 4);
  endtask

  task automatic test_program();
    tname = "program";
    key(4'hF);
    enter_code(1, 2, 3, 4);
    enter_code(9, 8, 7, 6);
    enter_code(1, 2, 3, 4);
    enter_code(9, 8, 7, 6);
    enter_code(9, 8, 7, 6);
  endtask

  task automatic test_timeout_hold();
    tname = "timeout";
    key(4'h1);
    key(4'h2);
    repeat (TIMEOUT_TICKS) press(4'h0);
    tname = "hold";
    repeat (5) press(4'h7);
    press(4'h0);
    key(4'hE);
  endtask

  task automatic test_clear();
    tname = "clear";
    key(4'h1); key(4'h2); key(4'hE);
    key(4'h3); key(4'hF); key(4'hE);
    key(4'hE);
    enter_code(m_code[0], m_code[1], m_code[2], m_code[3]);
    key(4'hF);
    key(4'h1);
    key(4'hE);
    enter_code(m_code[0], m_code[1], m_code[2], m_code[3]);
  endtask

  task automatic test_lockout();
    int bad;
    tname = "lockout";
    bad = (m_code[3] == 13) ? 12 : 13;
    repeat (3) enter_code(m_code[0], m_code[1], m_code[2], bad);
    enter_code(m_code[0], m_code[1], m_code[2], m_code[3]);
    for (int i = 0; i < 2 * LOCKOUT_TICKS && m_mode == MLock; i++) press(4'h0);
    enter_code(m_code[0], m_code[1], m_code[2], m_code[3]);
  endtask

  task automatic test_random();
    int r, hold, rel;
    logic [3:0] k;
    tname = "random";
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       k = 4'($urandom_range(1, 4));
      else if (r == 6) k = 4'hE;
      else if (r == 7) k = 4'hF;
      else if (r == 8) k = 4'($urandom_range(5, 13));
      else             k = 4'h0;
      if (k == 4'h0) begin
        repeat (TIMEOUT_TICKS + 1) press(4'h0);
      end else begin
        hold = int'($urandom_range(1, 3));
        rel  = int'($urandom_range(1, 2));
        repeat (hold) press(k);
        repeat (rel) press(4'h0);
      end
    end
  endtask

  task automatic test_async_reset();
    tname = "async_reset";
    key(4'h1); key(4'h2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_zero("asserted mid-entry");
    kif.keypad = 4'h0; kif.ENA = 1'b0; kif.is_armed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    enter_code(1, 2, 3, 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arm();
    test_disarm();
    test_program();
    test_timeout_hold();
    test_clear();
    test_lockout();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
